ext_mem_model_pipelined: RTL and testbench
==========================================

Name: ext_mem_model_pipelined

Overview:
- Parametrised successor to the single-latency external memory model used by the processor test harness.
- Sits between riscv_top's memory port and the harness, on the same valid/ready request channel, write-data channel and untagged-ready response channel.
- Adds configurable fixed read latency, a bounded number of outstanding reads, and an external stall input for back-pressure testing.
- Byte-masked writes and in-order tagged read responses.

Parameters:
- DATA_BITS, 128, width of one memory word and data buses.
- ADDR_BITS, 28, word-address width.
- TAG_BITS, 5, request/response tag width.
- DEPTH_LOG2, 16, log2 of storage words; index = addr[DEPTH_LOG2-1:0], upper bits ignored (aliasing).
- READ_LATENCY, 4, cycles from read accept to response (legal range 1..16).
- MAX_OUTSTANDING, 4, max reads in flight (1..READ_LATENCY).

Ports:
- clk  in  1  clock, all state on posedge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  when 1, forces mem_req_ready=0 and mem_req_data_ready=0.
- mem_req_valid  in  1  request valid.
- mem_req_ready  out  1  request accepted when valid&ready.
- mem_req_rw  in  1  1=write, 0=read.
- mem_req_addr  in  ADDR_BITS  word address.
- mem_req_tag  in  TAG_BITS  request tag.
- mem_req_data_valid  in  1  write data valid.
- mem_req_data_ready  out  1  write data accepted when valid&ready.
- mem_req_data_bits  in  DATA_BITS  write data.
- mem_req_data_mask  in  DATA_BITS/8  byte enables, bit i covers bits [8i+7:8i].
- mem_resp_valid  out  1  read response valid; no ready, consumer must take it.
- mem_resp_tag  out  TAG_BITS  tag of the responding read.
- mem_resp_data  out  DATA_BITS  read data.

Behaviour:
- Storage: internal array ram[0:2**DEPTH_LOG2-1] of DATA_BITS. It is not cleared by reset and is loadable by hierarchical $readmemh.
- FSM states and ready outputs:
  - IDLE: mem_req_ready = !stall && (outstanding < MAX_OUTSTANDING).
  - WDATA: mem_req_ready=0, mem_req_data_ready=!stall.
  - mem_req_data_ready is 0 in IDLE.
- Read accept (IDLE, valid&ready, rw=0):
  - ram[index] is snapshotted that cycle and enters stage 0 of a READ_LATENCY-deep pipeline of {valid, tag, data}.
  - The response appears with mem_resp_valid=1 exactly READ_LATENCY posedges after the accepting edge, for one cycle.
  - Responses are strictly in acceptance order. Back-to-back reads give back-to-back responses.
- Write accept (IDLE, valid&ready, rw=1): latch index, go to WDATA.
  - On data handshake, update only the masked bytes of ram[index] at that posedge, then return to IDLE.
  - mask=0 is a legal no-op write.
  - Writes produce no response.
- Ordering:
  - A read accepted on a cycle after the write-data handshake sees the new data.
  - Reads already in flight keep their snapshot and never observe later writes.
- Outstanding counter (width clog2(MAX_OUTSTANDING+1)):
  - +1 on read accept, -1 on response issue, unchanged when both happen in the same cycle.
  - It never exceeds MAX_OUTSTANDING or goes below 0.
- Stall: deasserts both readies combinationally. It does not freeze the response pipeline; in-flight reads still complete on time.
- mem_resp_tag/mem_resp_data hold their last value when valid=0. The consumer must ignore them.
- Reset (async, any time, including mid-write or with reads in flight):
  - state=IDLE, pipeline valids=0, outstanding=0, mem_resp_valid=0, mem_resp_tag=0, mem_resp_data=0.
  - Pending write data is discarded; ram is untouched.
  - mem_req_ready is 1 after reset when stall=0.
- Simulation-only check: $display an error if mem_req_valid is high with rw=1 while in WDATA (protocol violation). This does not affect behaviour.

Test Plan:
- Single read: ram preloaded with ram[5]=0x...00AB; read addr=5 tag=3 accepted at cycle T -> resp_valid=1 at T+4 (READ_LATENCY=4), tag=3, data=0x...00AB, valid low at T+5.
- Masked write then read: write addr=7 data=0xFF..FF mask=0x000F over ram[7]=0 -> following read of 7 returns 0x0000_0000_0000_0000_0000_0000_FFFF_FFFF.
- Outstanding limit: MAX_OUTSTANDING=2, READ_LATENCY=4, continuous reads tags 0..5 -> ready drops after 2 accepts; at most 2 in flight; responses in tag order 0..5 with no duplicates or loss.
- Snapshot ordering: read addr=9 (old=0x1) accepted, write 0x2 to 9 completes before it returns -> in-flight response data=0x1; next read returns 0x2.
- Stall: stall=1 for 10 cycles with reads in flight -> req_ready=0 and data_ready=0 throughout; in-flight responses still arrive at accept+READ_LATENCY.
- Async reset mid-operation: assert reset between cycles while in WDATA with 2 reads in flight -> resp_valid=0 immediately; no stale responses after release; ram unchanged; first post-reset read returns correct data.

Source files
------------

// File: rtl/ext_mem_model_pipelined_if.sv
// Memory port between the core-side harness and the pipelined external memory model.
// The core side drives requests and write data; the memory side drives readies and responses.
interface ext_mem_model_pipelined_if #(
    parameter int DATA_BITS = 128,
    parameter int ADDR_BITS = 28,
    parameter int TAG_BITS  = 5
);
    logic                   mem_req_valid;
    logic                   mem_req_ready;
    logic                   mem_req_rw;
    logic [ADDR_BITS-1:0]   mem_req_addr;
    logic [TAG_BITS-1:0]    mem_req_tag;
    logic                   mem_req_data_valid;
    logic                   mem_req_data_ready;
    logic [DATA_BITS-1:0]   mem_req_data_bits;
    logic [DATA_BITS/8-1:0] mem_req_data_mask;
    logic                   mem_resp_valid;
    logic [TAG_BITS-1:0]    mem_resp_tag;
    logic [DATA_BITS-1:0]   mem_resp_data;

    modport master (
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
               mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
        input  mem_req_ready, mem_req_data_ready,
               mem_resp_valid, mem_resp_tag, mem_resp_data
    );

    modport slave (
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
               mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
        output mem_req_ready, mem_req_data_ready,
               mem_resp_valid, mem_resp_tag, mem_resp_data
    );
endinterface

// File: rtl/ext_mem_model_pipelined.sv
// External memory model with fixed read latency, bounded outstanding reads,
// byte-masked writes and an external stall for back-pressure.
module ext_mem_model_pipelined #(
    parameter int DATA_BITS       = 128,
    parameter int ADDR_BITS       = 28,
    parameter int TAG_BITS        = 5,
    parameter int DEPTH_LOG2      = 16,
    parameter int READ_LATENCY    = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    ext_mem_model_pipelined_if.slave bus
);
    localparam int DEPTH     = 2 ** DEPTH_LOG2;
    localparam int MASK_BITS = DATA_BITS / 8;
    localparam int CNT_W     = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic {IDLE, WDATA} state_t;

    state_t                  state, state_nxt;
    logic [DATA_BITS-1:0]    ram [0:DEPTH-1];
    logic [DEPTH_LOG2-1:0]   idx, widx;
    logic [CNT_W-1:0]        outstanding;
    logic                    req_ready, data_ready;
    logic                    rd_acc, wr_acc, wd_acc;

    logic [READ_LATENCY-1:0]                vld_pipe;
    logic [READ_LATENCY-1:0][TAG_BITS-1:0]  tag_pipe;
    logic [READ_LATENCY-1:0][DATA_BITS-1:0] data_pipe;

    logic                    resp_valid;
    logic [TAG_BITS-1:0]     resp_tag;
    logic [DATA_BITS-1:0]    resp_data;

    // Upper address bits are ignored, so addresses alias modulo the depth.
    assign idx = bus.mem_req_addr[DEPTH_LOG2-1:0];

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        data_ready = 1'b0;
        case (state)
            IDLE: begin
                req_ready = !stall && (outstanding < MAX_CNT);
                if (bus.mem_req_valid && req_ready && bus.mem_req_rw)
                    state_nxt = WDATA;
            end
            WDATA: begin
                data_ready = !stall;
                if (bus.mem_req_data_valid && data_ready)
                    state_nxt = IDLE;
            end
        endcase
    end

    assign rd_acc = bus.mem_req_valid && req_ready && !bus.mem_req_rw;
    assign wr_acc = bus.mem_req_valid && req_ready && bus.mem_req_rw;
    assign wd_acc = bus.mem_req_data_valid && data_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (wr_acc) widx <= idx;
    end

    always_ff @(posedge clk) begin
        if (wd_acc) begin
            for (int b = 0; b < MASK_BITS; b++)
                if (bus.mem_req_data_mask[b])
                    ram[widx][8*b +: 8] <= bus.mem_req_data_bits[8*b +: 8];
        end
    end

    // Read data is captured at accept, so later writes never reach in-flight reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= rd_acc;
            for (int i = 1; i < READ_LATENCY; i++)
                vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    always_ff @(posedge clk) begin
        tag_pipe[0]  <= bus.mem_req_tag;
        data_pipe[0] <= ram[idx];
        for (int i = 1; i < READ_LATENCY; i++) begin
            tag_pipe[i]  <= tag_pipe[i-1];
            data_pipe[i] <= data_pipe[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_tag   <= '0;
            resp_data  <= '0;
        end else begin
            resp_valid <= vld_pipe[READ_LATENCY-1];
            if (vld_pipe[READ_LATENCY-1]) begin
                resp_tag  <= tag_pipe[READ_LATENCY-1];
                resp_data <= data_pipe[READ_LATENCY-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outstanding <= '0;
        end else begin
            case ({rd_acc, vld_pipe[READ_LATENCY-1]})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    assign bus.mem_req_ready      = req_ready;
    assign bus.mem_req_data_ready = data_ready;
    assign bus.mem_resp_valid     = resp_valid;
    assign bus.mem_resp_tag       = resp_tag;
    assign bus.mem_resp_data      = resp_data;

    // A new write request while the previous write's data is pending is a harness bug.
    wr_during_wdata: assert property (@(posedge clk) disable iff (reset)
        !(state == WDATA && bus.mem_req_valid && bus.mem_req_rw))
        else $error("ext_mem_model_pipelined: write request while awaiting write data");
endmodule

// File: tb/tb_ext_mem_model_pipelined.sv
// Bench for ext_mem_model_pipelined: directed scenarios plus random traffic,
// scored against a transaction-level memory model with a response queue.
module tb_ext_mem_model_pipelined;
    localparam int DB = 128, AB = 28, TB = 5, DL = 8, RL = 4, MO = 3;
    localparam int MB = DB / 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic stall = 1'b0;

    ext_mem_model_pipelined_if #(.DATA_BITS(DB), .ADDR_BITS(AB), .TAG_BITS(TB)) bus ();

    ext_mem_model_pipelined #(
        .DATA_BITS(DB), .ADDR_BITS(AB), .TAG_BITS(TB),
        .DEPTH_LOG2(DL), .READ_LATENCY(RL), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .stall (stall),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TB-1:0] tag;
        logic [DB-1:0] data;
        int            due;
    } rsp_t;

    rsp_t          pend[$];
    logic [DB-1:0] mem_m [2**DL];
    logic [TB-1:0] log_tag[$];
    logic [DB-1:0] log_data[$];
    logic [TB-1:0] exp_tag;
    logic [DB-1:0] exp_data;
    bit            in_wd, acc, dacc;
    int            widx, cyc;
    int            checks, errors;

    task automatic chk(input string name, input logic [DB-1:0] got, input logic [DB-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // One clock of traffic: drive inputs, check readies against the model,
    // advance the model by the handshakes it predicts, then check responses.
    task automatic step(input bit st, input bit v, input bit rw, input logic [AB-1:0] a,
                        input logic [TB-1:0] t, input bit dv, input logic [DB-1:0] d,
                        input logic [MB-1:0] m);
        bit er, edr, ev;
        int idx;
        stall                  = st;
        bus.mem_req_valid      = v;
        bus.mem_req_rw         = rw;
        bus.mem_req_addr       = a;
        bus.mem_req_tag        = t;
        bus.mem_req_data_valid = dv;
        bus.mem_req_data_bits  = d;
        bus.mem_req_data_mask  = m;
        #1;
        er  = !st && !in_wd && (pend.size() < MO);
        edr = !st && in_wd;
        chk("req_ready", DB'(bus.mem_req_ready), DB'(er));
        chk("data_ready", DB'(bus.mem_req_data_ready), DB'(edr));
        acc  = v && er;
        dacc = dv && edr;
        idx  = int'(a) % (2**DL);
        @(posedge clk);
        #1;
        cyc++;
        if (dacc) begin
            for (int b = 0; b < MB; b++)
                if (m[b]) mem_m[widx][8*b +: 8] = d[8*b +: 8];
            in_wd = 1'b0;
        end
        if (acc && rw) begin
            in_wd = 1'b1;
            widx  = idx;
        end
        if (acc && !rw) pend.push_back('{tag: t, data: mem_m[idx], due: cyc + RL});
        ev = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            ev       = 1'b1;
            exp_tag  = pend[0].tag;
            exp_data = pend[0].data;
            log_tag.push_back(exp_tag);
            log_data.push_back(exp_data);
            void'(pend.pop_front());
        end
        chk("resp_valid", DB'(bus.mem_resp_valid), DB'(ev));
        chk("resp_tag", DB'(bus.mem_resp_tag), DB'(exp_tag));
        chk("resp_data", bus.mem_resp_data, exp_data);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, 0, '0, '0);
    endtask

    task automatic rd(input logic [AB-1:0] a, input logic [TB-1:0] t);
        int n = 0;
        do begin
            step(0, 1, 0, a, t, 0, '0, '0);
            n++;
        end while (!acc && n < 100);
        chk("rd_accept", DB'(acc), DB'(1));
    endtask

    task automatic wreq(input logic [AB-1:0] a);
        int n = 0;
        do begin
            step(0, 1, 1, a, '0, 0, '0, '0);
            n++;
        end while (!acc && n < 100);
        chk("wr_accept", DB'(acc), DB'(1));
    endtask

    task automatic wr(input logic [AB-1:0] a, input logic [DB-1:0] d, input logic [MB-1:0] m);
        int n = 0;
        wreq(a);
        do begin
            step(0, 0, 0, '0, '0, 1, d, m);
            n++;
        end while (!dacc && n < 100);
        chk("wdata_accept", DB'(dacc), DB'(1));
    endtask

    task automatic drain();
        int n = 0;
        while (pend.size() > 0 && n < 50) begin
            idle(1);
            n++;
        end
        chk("drain", DB'(pend.size()), DB'(0));
    endtask

    task automatic clr_log();
        log_tag.delete();
        log_data.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_resp_valid", DB'(bus.mem_resp_valid), DB'(0));
        chk("rst_resp_tag", DB'(bus.mem_resp_tag), DB'(0));
        chk("rst_resp_data", bus.mem_resp_data, '0);
        pend.delete();
        in_wd    = 1'b0;
        exp_tag  = '0;
        exp_data = '0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
    endtask

    initial begin
        logic [DB-1:0] rnd;
        checks = 0; errors = 0; cyc = 0; in_wd = 1'b0;
        exp_tag = '0; exp_data = '0;
        bus.mem_req_valid = 1'b0; bus.mem_req_rw = 1'b0; bus.mem_req_addr = '0;
        bus.mem_req_tag = '0; bus.mem_req_data_valid = 1'b0;
        bus.mem_req_data_bits = '0; bus.mem_req_data_mask = '0;
        #12 reset = 1'b0;
        #1;
        chk("reset_resp_valid", DB'(bus.mem_resp_valid), DB'(0));
        chk("reset_resp_tag", DB'(bus.mem_resp_tag), DB'(0));
        chk("reset_resp_data", bus.mem_resp_data, '0);
        chk("reset_req_ready", DB'(bus.mem_req_ready), DB'(1));
        chk("reset_data_ready", DB'(bus.mem_req_data_ready), DB'(0));

        // Preload every word through the bus so the model knows the whole array.
        for (int i = 0; i < 2**DL; i++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            wr(AB'(i), rnd, '1);
        end
        wr(5, 128'hAB, '1);
        wr(7, '0, '1);
        wr(9, 128'h1, '1);

        clr_log();
        rd(5, 3);
        drain();
        chk("single_count", DB'(log_tag.size()), DB'(1));
        if (log_tag.size() > 0) begin
            chk("single_tag", DB'(log_tag[0]), DB'(3));
            chk("single_data", log_data[0], 128'hAB);
        end

        wr(7, '1, 16'h000F);
        clr_log();
        rd(7, 1);
        drain();
        if (log_data.size() > 0) chk("masked_data", log_data[0], 128'hFFFF_FFFF);

        clr_log();
        for (int t = 0; t < 6; t++) rd(AB'(100 + t), TB'(t));
        drain();
        chk("limit_count", DB'(log_tag.size()), DB'(6));
        for (int t = 0; t < 6 && t < log_tag.size(); t++)
            chk("limit_order", DB'(log_tag[t]), DB'(t));

        clr_log();
        rd(9, 10);
        wr(9, 128'h2, '1);
        rd(9, 11);
        drain();
        chk("snap_count", DB'(log_tag.size()), DB'(2));
        if (log_data.size() > 1) begin
            chk("snap_old", log_data[0], 128'h1);
            chk("snap_new", log_data[1], 128'h2);
        end

        rd(20, 1);
        rd(21, 2);
        for (int i = 0; i < 10; i++) step(1, 1, 0, 22, 3, 1, '1, '1);
        drain();

        clr_log();
        rd({20'hABCDE, 8'd5}, 4);
        drain();
        if (log_data.size() > 0) chk("alias_data", log_data[0], 128'hAB);

        rd(30, 1);
        rd(31, 2);
        wreq(30);
        do_reset();
        clr_log();
        idle(8);
        chk("post_reset_stale", DB'(log_tag.size()), DB'(0));
        rd(30, 5);
        drain();
        chk("post_reset_count", DB'(log_tag.size()), DB'(1));
        if (log_data.size() > 0) chk("post_reset_data", log_data[0], mem_m[30]);

        for (int i = 0; i < 3000; i++) begin
            bit st, v, rw;
            st  = ($urandom % 5) == 0;
            v   = $urandom % 2;
            rw  = in_wd ? 1'b0 : 1'(($urandom % 2));
            rnd = {$urandom, $urandom, $urandom, $urandom};
            step(st, v, rw, AB'($urandom), TB'($urandom), 1'($urandom % 2), rnd, MB'($urandom));
        end
        if (in_wd) step(0, 0, 0, '0, '0, 1, '0, '0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
